// File: rtl/bus_ctrl.sv
// Shared-bus master: sequences one register/RAM transfer per command by
// generating one-hot OE/WE strobes, the address, and optional immediate drive.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no strobes, bus released, ready for a command
// DRIVE   | address out, source enabled onto the bus
// STROBE  | as DRIVE plus destination write enable; rdata samples bus
// RELEASE | write enable dropped, source held, done pulses
// ERR     | rejected command, err pulses, no strobes
module bus_ctrl #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 8,
   parameter int N_DEV  = 4,
   parameter int SEL_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [SEL_W-1:0]  cmd_src,
   input  logic [SEL_W-1:0]  cmd_dst,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [WIDTH-1:0]  cmd_imm,
   output logic [N_DEV-1:0]  oe,
   output logic [N_DEV-1:0]  we,
   output logic [ADDR_W-1:0] addr_bus,
   inout  wire  [WIDTH-1:0]  data_bus,
   output logic [WIDTH-1:0]  rdata,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE, S_DRIVE, S_STROBE, S_RELEASE, S_ERR
   } state_t;

   localparam logic [SEL_W-1:0] IMM_SEL = SEL_W'(N_DEV);

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  src_q, src_d, dst_q, dst_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]  imm_q, imm_d, rdata_q, rdata_d;
   logic [N_DEV-1:0]  oe_q, oe_d, we_q, we_d;
   logic              drv_q, drv_d, done_q, done_d, err_q, err_d;
   logic              accept, legal, xfer_d, src_is_imm;

   assign cmd_ready = (state_q == S_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign legal     = (cmd_src <= IMM_SEL) && (cmd_dst < IMM_SEL) && (cmd_src != cmd_dst);

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      addr_d     = addr_q;
      imm_d      = imm_q;
      rdata_d    = rdata_q;
      xfer_d     = 1'b0;
      src_is_imm = 1'b0;
      oe_d       = '0;
      we_d       = '0;
      drv_d      = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               src_d = cmd_src;
               dst_d = cmd_dst;
               imm_d = cmd_imm;
               if (legal) begin
                  addr_d  = cmd_addr;
                  state_d = S_DRIVE;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_DRIVE:   state_d = S_STROBE;
         S_STROBE: begin
            state_d = S_RELEASE;
            rdata_d = data_bus;
         end
         S_RELEASE: state_d = S_IDLE;
         S_ERR:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      xfer_d     = (state_d == S_DRIVE) || (state_d == S_STROBE) || (state_d == S_RELEASE);
      src_is_imm = (src_d == IMM_SEL);
      oe_d       = (xfer_d && !src_is_imm) ? (N_DEV'(1) << src_d) : '0;
      drv_d      = xfer_d && src_is_imm;
      we_d       = (state_d == S_STROBE) ? (N_DEV'(1) << dst_d) : '0;
      done_d     = (state_d == S_RELEASE);
      err_d      = (state_d == S_ERR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         addr_q  <= '0;
         imm_q   <= '0;
         rdata_q <= '0;
         oe_q    <= '0;
         we_q    <= '0;
         drv_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         addr_q  <= addr_d;
         imm_q   <= imm_d;
         rdata_q <= rdata_d;
         oe_q    <= oe_d;
         we_q    <= we_d;
         drv_q   <= drv_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign oe       = oe_q;
   assign we       = we_q;
   assign addr_bus = addr_q;
   assign rdata    = rdata_q;
   assign done     = done_q;
   assign err      = err_q;
   assign data_bus = drv_q ? imm_q : 'z;

endmodule

// File: tb/tb_bus_ctrl.sv
// Randomized self-checking bench for bus_ctrl with a transaction-level model
// of the bus devices and the expected per-phase strobe pattern.
module tb_bus_ctrl;

   localparam int WIDTH  = 8;
   localparam int ADDR_W = 8;
   localparam int N_DEV  = 4;
   localparam int SEL_W  = 3;
   localparam logic [WIDTH-1:0] PARK = 8'h5A;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [SEL_W-1:0]  cmd_src = '0;
   logic [SEL_W-1:0]  cmd_dst = '0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [WIDTH-1:0]  cmd_imm = '0;
   logic [N_DEV-1:0]  oe, we;
   logic [ADDR_W-1:0] addr_bus;
   wire  [WIDTH-1:0]  data_bus;
   logic [WIDTH-1:0]  rdata;
   logic              done, err;

   bus_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .N_DEV(N_DEV), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_addr(cmd_addr), .cmd_imm(cmd_imm),
      .oe(oe), .we(we), .addr_bus(addr_bus), .data_bus(data_bus),
      .rdata(rdata), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Bus devices: drive when enabled, capture on write enable. When neither a
   // device nor the controller should drive, a parking pattern makes a stray
   // controller drive visible on the bus.
   logic [WIDTH-1:0] dev_mem [N_DEV];
   logic [WIDTH-1:0] dev_val;
   logic             exp_drv = 1'b0;
   logic             mem_load = 1'b1;
   logic             tb_en;

   always_comb begin
      dev_val = PARK;
      for (int i = 0; i < N_DEV; i++)
         if (oe[i]) dev_val = dev_mem[i];
   end
   assign tb_en    = (oe != '0) || !exp_drv;
   assign data_bus = tb_en ? dev_val : 'z;

   always @(posedge clk) begin
      for (int i = 0; i < N_DEV; i++) begin
         if (mem_load)   dev_mem[i] <= 8'(8'h30 + i * 17);
         else if (we[i]) dev_mem[i] <= data_bus;
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Strobe invariants on every cycle.
   always @(negedge clk) begin
      chk("oe_onehot0", 32'($onehot0(oe)), 32'd1);
      chk("we_onehot0", 32'($onehot0(we)), 32'd1);
      chk("we_has_src", 32'((we == '0) || (oe != '0) || exp_drv), 32'd1);
   end

   // Reference model state
   logic [WIDTH-1:0]  exp_mem [N_DEV];
   logic [WIDTH-1:0]  exp_rdata = '0;
   logic [ADDR_W-1:0] exp_addr  = '0;

   task automatic run_cmd(input logic [SEL_W-1:0] src, input logic [SEL_W-1:0] dst,
                          input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] imm);
      logic             lg;
      logic [WIDTH-1:0] val;
      lg  = (src <= 3'd4) && (dst < 3'd4) && (src != dst);
      val = (src == 3'd4) ? imm : ((src < 3'd4) ? exp_mem[src[1:0]] : 8'h00);
      @(negedge clk);
      chk("ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_src   = src;
      cmd_dst   = dst;
      cmd_addr  = addr;
      cmd_imm   = imm;
      exp_drv   = lg && (src == 3'd4);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_src   = 3'($urandom);
      cmd_dst   = 3'($urandom);
      cmd_addr  = 8'($urandom);
      cmd_imm   = 8'($urandom);
      if (lg) begin
         exp_addr = addr;
         for (int ph = 0; ph < 3; ph++) begin
            @(negedge clk);
            chk("oe", 32'(oe), (src == 3'd4) ? 32'd0 : (32'd1 << src));
            chk("we", 32'(we), (ph == 1) ? (32'd1 << dst) : 32'd0);
            chk("addr", 32'(addr_bus), 32'(exp_addr));
            chk("bus", 32'(data_bus), 32'(val));
            chk("done", 32'(done), 32'(ph == 2));
            chk("err_xfer", 32'(err), 32'd0);
            chk("ready_busy", 32'(cmd_ready), 32'd0);
            if (ph == 2) chk("rdata_rel", 32'(rdata), 32'(val));
            @(posedge clk); #1;
         end
         exp_mem[dst[1:0]] = val;
         exp_rdata = val;
         exp_drv   = 1'b0;
      end else begin
         @(negedge clk);
         chk("err", 32'(err), 32'd1);
         chk("oe_err", 32'(oe), 32'd0);
         chk("we_err", 32'(we), 32'd0);
         chk("addr_err", 32'(addr_bus), 32'(exp_addr));
         chk("ready_err", 32'(cmd_ready), 32'd0);
         chk("done_err", 32'(done), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("oe_idle", 32'(oe), 32'd0);
      chk("we_idle", 32'(we), 32'd0);
      chk("bus_idle", 32'(data_bus), 32'(PARK));
      chk("done_idle", 32'(done), 32'd0);
      chk("err_idle", 32'(err), 32'd0);
      chk("ready_back", 32'(cmd_ready), 32'd1);
      chk("rdata", 32'(rdata), 32'(exp_rdata));
      chk("addr_idle", 32'(addr_bus), 32'(exp_addr));
      if (lg) chk("dev_mem", 32'(dev_mem[dst[1:0]]), 32'(exp_mem[dst[1:0]]));
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc_n;
      int acc_cyc [2];
      logic [SEL_W-1:0] s, d;

      for (int i = 0; i < N_DEV; i++) exp_mem[i] = 8'(8'h30 + i * 17);

      // Reset values
      @(negedge clk);
      chk("rst_oe", 32'(oe), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_addr", 32'(addr_bus), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_bus", 32'(data_bus), 32'(PARK));
      @(negedge clk);
      rst = 1'b0;
      mem_load = 1'b0;

      // Directed: immediate write, device copy, illegal commands
      run_cmd(3'd4, 3'd1, 8'h00, 8'h0F);
      run_cmd(3'd1, 3'd3, 8'h20, 8'hEE);
      run_cmd(3'd2, 3'd2, 8'h33, 8'h11);
      run_cmd(3'd0, 3'd5, 8'h34, 8'h12);
      run_cmd(3'd6, 3'd0, 8'h35, 8'h13);

      // Back-to-back with cmd_valid held high
      acc_n = 0;
      acc_cyc[0] = 0;
      acc_cyc[1] = 0;
      cmd_src = 3'd1; cmd_dst = 3'd3; cmd_addr = 8'h40; cmd_imm = 8'h00;
      cmd_valid = 1'b1;
      for (int cyc = 0; cyc < 20 && acc_n < 2; cyc++) begin
         @(negedge clk);
         if (acc_n == 1) begin
            cmd_src = 3'd3; cmd_dst = 3'd0; cmd_addr = 8'h41;
         end
         if (cmd_ready) begin
            acc_cyc[acc_n] = cyc;
            acc_n++;
         end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      exp_mem[3] = exp_mem[1];
      exp_mem[0] = exp_mem[3];
      exp_rdata  = exp_mem[0];
      exp_addr   = 8'h41;
      chk("b2b_count", 32'(acc_n), 32'd2);
      chk("b2b_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
      repeat (4) @(negedge clk);
      chk("b2b_rdata", 32'(rdata), 32'(exp_rdata));
      chk("b2b_dev3", 32'(dev_mem[3]), 32'(exp_mem[3]));
      chk("b2b_dev0", 32'(dev_mem[0]), 32'(exp_mem[0]));
      chk("b2b_addr", 32'(addr_bus), 32'(exp_addr));

      // Randomized commands, mostly legal
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) != 0) begin
            s = 3'($urandom_range(0, 4));
            d = 3'($urandom_range(0, 3));
         end else begin
            s = 3'($urandom_range(0, 7));
            d = 3'($urandom_range(0, 7));
         end
         run_cmd(s, d, 8'($urandom), 8'($urandom));
      end

      // Async reset during STROBE of an immediate write
      @(negedge clk);
      cmd_valid = 1'b1; cmd_src = 3'd4; cmd_dst = 3'd2; cmd_addr = 8'h44; cmd_imm = 8'h96;
      exp_drv = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #2;
      chk("pre_rst_we", 32'(we), 32'd4);
      rst = 1'b1;
      exp_drv = 1'b0;
      #1;
      chk("arst_oe", 32'(oe), 32'd0);
      chk("arst_we", 32'(we), 32'd0);
      chk("arst_bus", 32'(data_bus), 32'(PARK));
      chk("arst_ready", 32'(cmd_ready), 32'd0);
      exp_rdata = '0;
      exp_addr  = '0;
      repeat (2) begin
         @(negedge clk);
         chk("arst_done", 32'(done), 32'd0);
         chk("arst_err", 32'(err), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_rdata", 32'(rdata), 32'd0);
      chk("post_rst_dev2", 32'(dev_mem[2]), 32'(exp_mem[2]));
      run_cmd(3'd2, 3'd1, 8'h55, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
